// File: rtl/alu_issue_stage.sv
// alu_issue_stage: execute-issue stage in front of the RV32I ALU.
// Decodes opcode/funct3/funct7[5] into the ALU control code, picks operands
// a/b from rs1/rs2/PC/immediate and registers the result behind a
// valid/ready handshake with a two-entry (main + skid) output buffer.
// The build option macro ALU_ISSUE_FWD_EN enables the EX/WB forwarding muxes.
// Without it the fwd_* ports are ignored.
module alu_issue_stage #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RF_ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  // Upstream side
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [6:0]           in_opcode,
  input  logic [2:0]           in_funct3,
  input  logic                 in_funct7b5,
  input  logic [RF_ADDR_W-1:0] in_rs1_addr,
  input  logic [RF_ADDR_W-1:0] in_rs2_addr,
  input  logic [XLEN-1:0]      in_rs1_data,
  input  logic [XLEN-1:0]      in_rs2_data,
  input  logic [XLEN-1:0]      in_imm,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [RF_ADDR_W-1:0] in_rd,
  // Writeback candidates from later stages
  input  logic                 fwd_ex_valid,
  input  logic [RF_ADDR_W-1:0] fwd_ex_rd,
  input  logic [XLEN-1:0]      fwd_ex_data,
  input  logic                 fwd_wb_valid,
  input  logic [RF_ADDR_W-1:0] fwd_wb_rd,
  input  logic [XLEN-1:0]      fwd_wb_data,
  // Downstream (ALU) side
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_a,
  output logic [XLEN-1:0]      out_b,
  output logic [3:0]           out_ctrl,
  output logic [RF_ADDR_W-1:0] out_rd,
  output logic [2:0]           out_funct3,
  output logic                 out_illegal
);

  // ALU control codes
  localparam logic [3:0] CtrlAdd  = 4'b0000;
  localparam logic [3:0] CtrlSlt  = 4'b0001;
  localparam logic [3:0] CtrlSltu = 4'b0010;
  localparam logic [3:0] CtrlXor  = 4'b0011;
  localparam logic [3:0] CtrlOr   = 4'b0100;
  localparam logic [3:0] CtrlAnd  = 4'b0111;
  localparam logic [3:0] CtrlSll  = 4'b1000;
  localparam logic [3:0] CtrlSrl  = 4'b1001;
  localparam logic [3:0] CtrlSra  = 4'b1010;
  localparam logic [3:0] CtrlSub  = 4'b1011;

  // Major opcodes
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;

  // Operand source selects
  localparam logic [1:0] ASelZero = 2'd0;
  localparam logic [1:0] ASelRs1  = 2'd1;
  localparam logic [1:0] ASelPc   = 2'd2;

  localparam logic [1:0] BSelZero = 2'd0;
  localparam logic [1:0] BSelRs2  = 2'd1;
  localparam logic [1:0] BSelImm  = 2'd2;
  localparam logic [1:0] BSelFour = 2'd3;

  localparam logic [XLEN-1:0] LinkOffset = {{(XLEN-3){1'b0}}, 3'b100};

  typedef struct packed {
    logic [XLEN-1:0]      a;
    logic [XLEN-1:0]      b;
    logic [3:0]           ctrl;
    logic [RF_ADDR_W-1:0] rd;
    logic [2:0]           funct3;
    logic                 illegal;
  } entry_t;

  logic [3:0]      dec_ctrl;
  logic [1:0]      dec_sel_a;
  logic [1:0]      dec_sel_b;
  logic            dec_illegal;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  entry_t          new_entry;

  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   accept;
  logic   main_free;

  // Instruction decode: ALU control code, operand sources and legality
  always_comb begin
    dec_ctrl    = CtrlAdd;
    dec_sel_a   = ASelZero;
    dec_sel_b   = BSelZero;
    dec_illegal = 1'b0;
    case (in_opcode)
      OpcOp, OpcOpImm: begin
        dec_sel_a = ASelRs1;
        dec_sel_b = (in_opcode == OpcOp) ? BSelRs2 : BSelImm;
        case (in_funct3)
          // funct7[5] selects SUB only in register form; ADDI ignores it
          3'b000: dec_ctrl = (in_opcode == OpcOp && in_funct7b5) ? CtrlSub : CtrlAdd;
          3'b001: dec_ctrl = CtrlSll;
          3'b010: dec_ctrl = CtrlSlt;
          3'b011: dec_ctrl = CtrlSltu;
          3'b100: dec_ctrl = CtrlXor;
          3'b101: dec_ctrl = in_funct7b5 ? CtrlSra : CtrlSrl;
          3'b110: dec_ctrl = CtrlOr;
          default: dec_ctrl = CtrlAnd;
        endcase
      end
      OpcLui: begin
        dec_sel_a = ASelZero;
        dec_sel_b = BSelImm;
      end
      OpcAuipc: begin
        dec_sel_a = ASelPc;
        dec_sel_b = BSelImm;
      end
      OpcLoad, OpcStore: begin
        dec_sel_a = ASelRs1;
        dec_sel_b = BSelImm;
      end
      OpcBranch: begin
        dec_sel_a = ASelRs1;
        dec_sel_b = BSelRs2;
        // Branch compare: equality via SUB, ordering via SLT/SLTU
        case (in_funct3[2:1])
          2'b00:   dec_ctrl = CtrlSub;
          2'b10:   dec_ctrl = CtrlSlt;
          2'b11:   dec_ctrl = CtrlSltu;
          default: dec_illegal = 1'b1;
        endcase
      end
      OpcJal, OpcJalr: begin
        // Link value pc + 4; target is computed elsewhere
        dec_sel_a = ASelPc;
        dec_sel_b = BSelFour;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

`ifdef ALU_ISSUE_FWD_EN
  // Source operand resolution: EX result beats WB result beats register file; x0 never forwards
  always_comb begin
    rs1_val = in_rs1_data;
    if (in_rs1_addr != '0) begin
      if (fwd_ex_valid && fwd_ex_rd == in_rs1_addr) begin
        rs1_val = fwd_ex_data;
      end else if (fwd_wb_valid && fwd_wb_rd == in_rs1_addr) begin
        rs1_val = fwd_wb_data;
      end
    end
    rs2_val = in_rs2_data;
    if (in_rs2_addr != '0) begin
      if (fwd_ex_valid && fwd_ex_rd == in_rs2_addr) begin
        rs2_val = fwd_ex_data;
      end else if (fwd_wb_valid && fwd_wb_rd == in_rs2_addr) begin
        rs2_val = fwd_wb_data;
      end
    end
  end
`else
  // Forwarding disabled: operands come straight from the register file
  assign rs1_val = in_rs1_data;
  assign rs2_val = in_rs2_data;

  logic unused_fwd;
  assign unused_fwd = ^{fwd_ex_valid, fwd_ex_rd, fwd_ex_data, fwd_wb_valid, fwd_wb_rd,
                        fwd_wb_data, in_rs1_addr, in_rs2_addr};
`endif

  // Operand muxes and assembly of the entry to be registered
  always_comb begin
    new_entry = '0;
    case (dec_sel_a)
      ASelRs1: new_entry.a = rs1_val;
      ASelPc:  new_entry.a = in_pc;
      default: new_entry.a = '0;
    endcase
    case (dec_sel_b)
      BSelRs2:  new_entry.b = rs2_val;
      BSelImm:  new_entry.b = in_imm;
      BSelFour: new_entry.b = LinkOffset;
      default:  new_entry.b = '0;
    endcase
    new_entry.ctrl    = dec_ctrl;
    new_entry.rd      = in_rd;
    new_entry.funct3  = in_funct3;
    new_entry.illegal = dec_illegal;
  end

  // in_ready depends on registered state only, so out_ready never reaches upstream
  assign in_ready  = ~skid_valid_q;
  assign accept    = in_valid & in_ready & ~flush;
  assign main_free = ~main_valid_q | out_ready;

  // Main/skid next state: skid refills main first to keep FIFO order
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_free) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = new_entry;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = new_entry;
      skid_valid_d = 1'b1;
    end
  end

  // Buffer state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid   = main_valid_q;
  assign out_a       = main_q.a;
  assign out_b       = main_q.b;
  assign out_ctrl    = main_q.ctrl;
  assign out_rd      = main_q.rd;
  assign out_funct3  = main_q.funct3;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenario tasks plus a
// randomized run checked by a queue-based reference model.
`timescale 1ns/1ps
module tb_alu_issue_stage;

  localparam logic [3:0] CAdd = 4'b0000, CSlt = 4'b0001, CSltu = 4'b0010, CXor = 4'b0011;
  localparam logic [3:0] COr = 4'b0100, CAnd = 4'b0111, CSll = 4'b1000, CSrl = 4'b1001;
  localparam logic [3:0] CSra = 4'b1010, CSub = 4'b1011;

`ifdef ALU_ISSUE_FWD_EN
  localparam bit FwdEn = 1'b1;
`else
  localparam bit FwdEn = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        ill;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, in_funct7b5;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
  logic        fwd_ex_valid, fwd_wb_valid;
  logic [4:0]  fwd_ex_rd, fwd_wb_rd;
  logic [31:0] fwd_ex_data, fwd_wb_data;
  logic        out_valid, out_ready, out_illegal;
  logic [31:0] out_a, out_b;
  logic [3:0]  out_ctrl;
  logic [4:0]  out_rd;
  logic [2:0]  out_funct3;

  int   n_chk = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  ent_t scb[$];
  logic [6:0] legal_ops [9] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67};

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_pc(in_pc), .in_rd(in_rd),
    .fwd_ex_valid(fwd_ex_valid), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
    .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_ctrl(out_ctrl), .out_rd(out_rd),
    .out_funct3(out_funct3), .out_illegal(out_illegal)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] src_val(input logic [4:0] addr, input logic [31:0] rf);
    if (FwdEn && addr != 5'd0 && fwd_ex_valid && fwd_ex_rd == addr) return fwd_ex_data;
    if (FwdEn && addr != 5'd0 && fwd_wb_valid && fwd_wb_rd == addr) return fwd_wb_data;
    return rf;
  endfunction

  function automatic logic [3:0] arith(input logic [2:0] f3, input logic f7, input bit reg_form);
    logic [3:0] tbl [8];
    tbl = '{CAdd, CSll, CSlt, CSltu, CXor, CSrl, COr, CAnd};
    if (f3 == 3'b000 && reg_form && f7) return CSub;
    if (f3 == 3'b101 && f7) return CSra;
    return tbl[f3];
  endfunction

  function automatic ent_t model();
    ent_t e;
    logic [31:0] s1, s2;
    s1 = src_val(in_rs1_addr, in_rs1_data);
    s2 = src_val(in_rs2_addr, in_rs2_data);
    e = '0;
    e.rd = in_rd;
    e.f3 = in_funct3;
    e.ctrl = CAdd;
    case (in_opcode)
      7'h33: begin e.a = s1; e.b = s2;  e.ctrl = arith(in_funct3, in_funct7b5, 1'b1); end
      7'h13: begin e.a = s1; e.b = in_imm; e.ctrl = arith(in_funct3, in_funct7b5, 1'b0); end
      7'h37: begin e.a = 32'd0; e.b = in_imm; end
      7'h17: begin e.a = in_pc; e.b = in_imm; end
      7'h03, 7'h23: begin e.a = s1; e.b = in_imm; end
      7'h6F, 7'h67: begin e.a = in_pc; e.b = 32'd4; end
      7'h63: begin
        e.a = s1;
        e.b = s2;
        if (in_funct3 == 3'b000 || in_funct3 == 3'b001) e.ctrl = CSub;
        else if (in_funct3 == 3'b100 || in_funct3 == 3'b101) e.ctrl = CSlt;
        else if (in_funct3 == 3'b110 || in_funct3 == 3'b111) e.ctrl = CSltu;
        else e.ill = 1'b1;
      end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // Scoreboard: the stage behaves as a 2-deep FIFO with in_ready = (occupancy < 2)
  always @(negedge clk) begin
    if (mon_en) begin
      ent_t got;
      bit   can_take;
      got = '{a: out_a, b: out_b, ctrl: out_ctrl, rd: out_rd, f3: out_funct3, ill: out_illegal};
      can_take = (scb.size() < 2);
      n_chk++;
      if (out_valid !== (scb.size() != 0)) begin
        n_fail++;
        $display("FAIL scb_out_valid: got %b want %b at %0t", out_valid, scb.size() != 0, $time);
      end
      n_chk++;
      if (in_ready !== can_take) begin
        n_fail++;
        $display("FAIL scb_in_ready: got %b want %b at %0t", in_ready, can_take, $time);
      end
      if (out_valid === 1'b1 && scb.size() != 0) begin
        n_chk++;
        if (got !== scb[0]) begin
          n_fail++;
          $display("FAIL scb_entry: got a=%h b=%h ctrl=%b rd=%0d f3=%0d ill=%b want a=%h b=%h ctrl=%b rd=%0d f3=%0d ill=%b at %0t",
                   got.a, got.b, got.ctrl, got.rd, got.f3, got.ill,
                   scb[0].a, scb[0].b, scb[0].ctrl, scb[0].rd, scb[0].f3, scb[0].ill, $time);
        end
      end
      if (!rst_n || flush) begin
        scb.delete();
      end else begin
        if (out_ready && scb.size() != 0) void'(scb.pop_front());
        if (in_valid && can_take) scb.push_back(model());
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic [4:0] r1a, input logic [4:0] r2a,
                       input logic [31:0] r1d, input logic [31:0] r2d,
                       input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd);
    in_valid = 1'b1; in_opcode = op; in_funct3 = f3; in_funct7b5 = f7;
    in_rs1_addr = r1a; in_rs2_addr = r2a; in_rs1_data = r1d; in_rs2_data = r2d;
    in_imm = imm; in_pc = pc; in_rd = rd;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    fwd_ex_valid = 1'b0; fwd_ex_rd = '0; fwd_ex_data = '0;
    fwd_wb_valid = 1'b0; fwd_wb_rd = '0; fwd_wb_data = '0;
    drive(7'h33, 3'd0, 1'b0, 5'd1, 5'd2, 32'd7, 32'd8, 32'd0, 32'd0, 5'd9);
    tick();
    mon_en = 1'b1;
    tick();
    rst_n = 1'b1;
    in_valid = 1'b0;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    n_chk++;
    if ({out_a, out_b, out_ctrl, out_rd, out_funct3, out_illegal} !== '0) begin
      n_fail++;
      $display("FAIL rst_fields: got a=%h b=%h ctrl=%b rd=%0d f3=%0d ill=%b want all zero",
               out_a, out_b, out_ctrl, out_rd, out_funct3, out_illegal);
    end
    tick();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_dropped: got %b want 0", out_valid); end
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    drive(7'h33, 3'd0, 1'b0, 5'd1, 5'd2, 32'd15, 32'd10, 32'd0, 32'h100, 5'd3);
    tick();
    in_valid = 1'b0;
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %b want 1", out_valid); end
    n_chk++; if (out_ctrl !== CAdd) begin n_fail++; $display("FAIL add_ctrl: got %b want 0000", out_ctrl); end
    n_chk++; if (out_a !== 32'd15) begin n_fail++; $display("FAIL add_a: got %0d want 15", out_a); end
    n_chk++; if (out_b !== 32'd10) begin n_fail++; $display("FAIL add_b: got %0d want 10", out_b); end
    n_chk++; if (out_rd !== 5'd3) begin n_fail++; $display("FAIL add_rd: got %0d want 3", out_rd); end
    tick();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_bubble: got %b want 0", out_valid); end
  endtask

  task automatic test_decode();
    out_ready = 1'b1;
    drive(7'h33, 3'b000, 1'b1, 5'd1, 5'd2, 32'd9, 32'd3, 32'd0, 32'd0, 5'd1);
    tick(); in_valid = 1'b0;
    n_chk++; if (out_ctrl !== CSub) begin n_fail++; $display("FAIL dec_sub: got %b want 1011", out_ctrl); end
    tick();
    drive(7'h13, 3'b101, 1'b1, 5'd3, 5'd4, 32'd4, 32'd77, 32'd1, 32'd0, 5'd2);
    tick(); in_valid = 1'b0;
    n_chk++; if (out_ctrl !== CSra) begin n_fail++; $display("FAIL dec_srai_ctrl: got %b want 1010", out_ctrl); end
    n_chk++; if (out_b !== 32'd1) begin n_fail++; $display("FAIL dec_srai_b: got %h want 1", out_b); end
    n_chk++; if (out_a !== 32'd4) begin n_fail++; $display("FAIL dec_srai_a: got %h want 4", out_a); end
    tick();
    drive(7'h63, 3'b110, 1'b0, 5'd3, 5'd4, 32'd5, 32'd6, 32'h40, 32'h200, 5'd0);
    tick(); in_valid = 1'b0;
    n_chk++; if (out_ctrl !== CSltu) begin n_fail++; $display("FAIL dec_bltu: got %b want 0010", out_ctrl); end
    n_chk++; if (out_illegal !== 1'b0) begin n_fail++; $display("FAIL dec_bltu_ill: got %b want 0", out_illegal); end
    tick();
    drive(7'h63, 3'b010, 1'b0, 5'd3, 5'd4, 32'd5, 32'd6, 32'h40, 32'h200, 5'd0);
    tick(); in_valid = 1'b0;
    n_chk++; if (out_illegal !== 1'b1) begin n_fail++; $display("FAIL dec_br010_ill: got %b want 1", out_illegal); end
    tick();
    drive(7'h7F, 3'b000, 1'b0, 5'd3, 5'd4, 32'hDEAD, 32'hBEEF, 32'h40, 32'h200, 5'd5);
    tick(); in_valid = 1'b0;
    n_chk++; if (out_illegal !== 1'b1) begin n_fail++; $display("FAIL dec_bad_ill: got %b want 1", out_illegal); end
    n_chk++;
    if (out_a !== 32'd0 || out_b !== 32'd0 || out_ctrl !== CAdd) begin
      n_fail++; $display("FAIL dec_bad_ops: got a=%h b=%h ctrl=%b want 0 0 0000", out_a, out_b, out_ctrl);
    end
    tick();
    drive(7'h17, 3'b000, 1'b0, 5'd3, 5'd4, 32'd1, 32'd2, 32'h1000, 32'h80, 5'd6);
    tick(); in_valid = 1'b0;
    n_chk++;
    if (out_a !== 32'h80 || out_b !== 32'h1000) begin
      n_fail++; $display("FAIL dec_auipc: got a=%h b=%h want 80 1000", out_a, out_b);
    end
    tick();
    drive(7'h6F, 3'b000, 1'b0, 5'd3, 5'd4, 32'd1, 32'd2, 32'h1000, 32'h84, 5'd1);
    tick(); in_valid = 1'b0;
    n_chk++;
    if (out_a !== 32'h84 || out_b !== 32'd4 || out_ctrl !== CAdd) begin
      n_fail++; $display("FAIL dec_jal: got a=%h b=%h ctrl=%b want 84 4 0000", out_a, out_b, out_ctrl);
    end
    tick();
  endtask

  task automatic test_forward();
    out_ready = 1'b1;
    fwd_ex_valid = 1'b1; fwd_ex_rd = 5'd5; fwd_ex_data = 32'hAA;
    fwd_wb_valid = 1'b1; fwd_wb_rd = 5'd5; fwd_wb_data = 32'hBB;
    drive(7'h33, 3'd0, 1'b0, 5'd5, 5'd6, 32'h11, 32'h22, 32'd0, 32'd0, 5'd1);
    tick(); in_valid = 1'b0;
    n_chk++;
    if (out_a !== (FwdEn ? 32'hAA : 32'h11)) begin
      n_fail++; $display("FAIL fwd_ex_wins: got %h want %h", out_a, FwdEn ? 32'hAA : 32'h11);
    end
    tick();
    fwd_ex_rd = 5'd0; fwd_wb_rd = 5'd0;
    drive(7'h33, 3'd0, 1'b0, 5'd0, 5'd6, 32'h33, 32'h22, 32'd0, 32'd0, 5'd1);
    tick(); in_valid = 1'b0;
    n_chk++; if (out_a !== 32'h33) begin n_fail++; $display("FAIL fwd_x0: got %h want 33", out_a); end
    tick();
    fwd_ex_rd = 5'd6; fwd_wb_rd = 5'd7;
    drive(7'h33, 3'd0, 1'b0, 5'd1, 5'd7, 32'h44, 32'h55, 32'd0, 32'd0, 5'd1);
    tick(); in_valid = 1'b0;
    n_chk++;
    if (out_b !== (FwdEn ? 32'hBB : 32'h55)) begin
      n_fail++; $display("FAIL fwd_wb_rs2: got %h want %h", out_b, FwdEn ? 32'hBB : 32'h55);
    end
    tick();
    fwd_ex_rd = 5'd5;
    drive(7'h37, 3'd0, 1'b0, 5'd5, 5'd7, 32'h44, 32'h55, 32'h7000, 32'd0, 5'd1);
    tick(); in_valid = 1'b0;
    n_chk++; if (out_a !== 32'd0) begin n_fail++; $display("FAIL fwd_lui_a: got %h want 0", out_a); end
    tick();
    fwd_ex_valid = 1'b0; fwd_wb_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive(7'h33, 3'd0, 1'b0, 5'd1, 5'd2, 32'hA, 32'd1, 32'd0, 32'd0, 5'd1);
    tick();
    drive(7'h33, 3'd0, 1'b0, 5'd1, 5'd2, 32'hB, 32'd1, 32'd0, 32'd0, 5'd2);
    tick(); in_valid = 1'b0;
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full: got %b want 0", in_ready); end
    n_chk++; if (out_a !== 32'hA) begin n_fail++; $display("FAIL bp_head: got %h want a", out_a); end
    tick();
    n_chk++; if (out_a !== 32'hA || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_hold: got a=%h v=%b want a 1", out_a, out_valid);
    end
    out_ready = 1'b1;
    tick();
    n_chk++; if (out_a !== 32'hB || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_second: got a=%h v=%b want b 1", out_a, out_valid);
    end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready: got %b want 1", in_ready); end
    tick();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b want 0", out_valid); end
    for (int i = 0; i < 6; i++) begin
      drive(7'h33, 3'd0, 1'b0, 5'd1, 5'd2, 32'h100 + 32'(i), 32'd1, 32'd0, 32'd0, 5'd1);
      tick();
      n_chk++;
      if (out_valid !== 1'b1 || out_a !== 32'h100 + 32'(i) || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_%0d: got v=%b a=%h rdy=%b want 1 %h 1", i, out_valid, out_a, in_ready,
                 32'h100 + 32'(i));
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(7'h33, 3'd0, 1'b0, 5'd1, 5'd2, 32'h1, 32'd1, 32'd0, 32'd0, 5'd1);
    tick();
    drive(7'h33, 3'd0, 1'b0, 5'd1, 5'd2, 32'h2, 32'd1, 32'd0, 32'd0, 5'd1);
    tick();
    drive(7'h33, 3'd0, 1'b0, 5'd1, 5'd2, 32'h3, 32'd1, 32'd0, 32'd0, 5'd1);
    flush = 1'b1;
    tick(); flush = 1'b0; in_valid = 1'b0;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_full_valid: got %b want 0", out_valid); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_full_ready: got %b want 1", in_ready); end
    drive(7'h33, 3'd0, 1'b0, 5'd1, 5'd2, 32'h4, 32'd1, 32'd0, 32'd0, 5'd1);
    tick();
    drive(7'h33, 3'd0, 1'b0, 5'd1, 5'd2, 32'h5, 32'd1, 32'd0, 32'd0, 5'd1);
    flush = 1'b1;
    tick(); flush = 1'b0; in_valid = 1'b0;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop: got %b want 0", out_valid); end
    tick();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_late: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_stall();
    out_ready = 1'b0;
    drive(7'h13, 3'd4, 1'b0, 5'd1, 5'd2, 32'h6, 32'd1, 32'h9, 32'd0, 5'd4);
    tick();
    drive(7'h13, 3'd6, 1'b0, 5'd1, 5'd2, 32'h7, 32'd1, 32'h9, 32'd0, 5'd5);
    tick();
    drive(7'h33, 3'd1, 1'b0, 5'd1, 5'd2, 32'h8, 32'd1, 32'd0, 32'd0, 5'd6);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; in_valid = 1'b0;
    n_chk++;
    if ({out_valid, out_a, out_b, out_ctrl, out_rd, out_funct3, out_illegal} !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_stall: got v=%b a=%h b=%h ctrl=%b rd=%0d f3=%0d ill=%b rdy=%b want zeros rdy=1",
               out_valid, out_a, out_b, out_ctrl, out_rd, out_funct3, out_illegal, in_ready);
    end
    out_ready = 1'b1;
    tick();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_stall_after: got %b want 0", out_valid); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      in_opcode   = ($urandom_range(0, 7) == 0) ? 7'($urandom) : legal_ops[$urandom_range(0, 8)];
      in_funct3   = 3'($urandom);
      in_funct7b5 = 1'($urandom);
      in_rs1_addr = 5'($urandom_range(0, 7));
      in_rs2_addr = 5'($urandom_range(0, 7));
      in_rs1_data = $urandom; in_rs2_data = $urandom;
      in_imm = $urandom; in_pc = $urandom; in_rd = 5'($urandom);
      fwd_ex_valid = 1'($urandom); fwd_ex_rd = 5'($urandom_range(0, 7)); fwd_ex_data = $urandom;
      fwd_wb_valid = 1'($urandom); fwd_wb_rd = 5'($urandom_range(0, 7)); fwd_wb_data = $urandom;
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 39) == 0);
      rst_n     = ($urandom_range(0, 299) != 0);
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; rst_n = 1'b1; out_ready = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_decode();
    test_forward();
    test_back_to_back();
    test_flush();
    test_reset_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Execute-issue stage directly upstream of the RV32I ALU.
- Decodes opcode/funct3/funct7[5] into the 4-bit ALU ctrl code and selects operands a/b from rs1, rs2, PC and immediate.
- Applies EX/WB result forwarding.
- Registers the result behind a valid/ready handshake with a 2-entry skid buffer; the ALU consumes out_a/out_b/out_ctrl combinationally.

Parameters:
- XLEN, 32, datapath width
- RF_ADDR_W, 5, register address width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- flush  in  1  synchronous kill of all buffered entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept
- in_opcode  in  7  instruction[6:0]
- in_funct3  in  3  instruction[14:12]
- in_funct7b5  in  1  instruction[30]
- in_rs1_addr, in_rs2_addr  in  RF_ADDR_W  source register indices
- in_rs1_data, in_rs2_data  in  XLEN  register file read data
- in_imm  in  XLEN  sign-extended immediate, already formatted
- in_pc  in  XLEN  instruction PC
- in_rd  in  RF_ADDR_W  destination index
- fwd_ex_valid / fwd_ex_rd / fwd_ex_data  in  1 / RF_ADDR_W / XLEN  EX-stage writeback candidate
- fwd_wb_valid / fwd_wb_rd / fwd_wb_data  in  1 / RF_ADDR_W / XLEN  WB-stage writeback candidate
- out_valid  out  1  entry presented to ALU
- out_ready  in  1  downstream accepts
- out_a, out_b  out  XLEN  ALU operands
- out_ctrl  out  4  ALU control code
- out_rd  out  RF_ADDR_W  destination index
- out_funct3  out  3  passthrough, for branch resolution on zeroFlag/LessFlag
- out_illegal  out  1  unsupported opcode/funct combination

Behaviour:
- ctrl encoding is fixed:
  - ADD=0000, SLT=0001, SLTU=0010, XOR=0011, OR=0100, AND=0111
  - SLL=1000, SRL=1001, SRA=1010, SUB=1011
- OP (0110011) and OP-IMM (0010011); b=rs2 for OP, b=imm for OP-IMM; a=rs1:
  - funct3 000: ADD; SUB only for OP with funct7b5=1.
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
  - 101: SRA if funct7b5=1, else SRL.
- LUI 0110111: a=0, b=imm, ADD. AUIPC 0010111: a=pc, b=imm, ADD.
- LOAD 0000011 / STORE 0100011: a=rs1, b=imm, ADD.
- BRANCH 1100011: a=rs1, b=rs2.
  - funct3 000/001: SUB.
  - 100/101: SLT.
  - 110/111: SLTU.
  - 010/011: out_illegal=1.
- JAL 1101111 / JALR 1100111: a=pc, b=4, ADD (link value).
- Any other opcode: out_illegal=1, ctrl=ADD, a=b=0.
- Forwarding (per source, only where the operand uses rs1/rs2):
  - EX match (valid, rd==addr, rd!=0) wins over WB match; otherwise register data.
  - Forwarding inputs are sampled in the accept cycle.
- Handshake:
  - Input transfer when in_valid&in_ready; output transfer when out_valid&out_ready.
  - Latency is 1 cycle from accept to out_valid.
  - Output fields hold stable while out_valid&!out_ready.
- Skid buffer:
  - Main register plus skid register; in_ready = !skid_valid (registered state only, no combinational path from out_ready).
  - Accept while main is stalled: entry goes to skid. On drain, skid moves to main.
  - Simultaneous accept and drain with skid empty: main reloads in the same cycle, no bubble.
  - Order is strictly FIFO.
- flush: clears main_valid and skid_valid next edge; an input offered in the flush cycle is dropped; flush has priority over accept.
- Reset (rst_n=0 at edge):
  - out_valid=0, out_a=0, out_b=0, out_ctrl=0000, out_rd=0, out_funct3=0, out_illegal=0, skid empty.
  - in_ready=1 after reset; transfers offered during reset are dropped.
  - Reset mid-stall discards both entries.

Optional Feature:
- Macro ALU_ISSUE_FWD_EN.
- Defined: forwarding muxes as specified.
- Undefined: fwd_* ports remain but are ignored; operands always come from in_rs*_data.

Test Plan:
- Reset, then OP ADD with rs1=15, rs2=10, out_ready=1:
  - Next cycle out_valid=1, out_ctrl=0000, out_a=15, out_b=10.
  - Then out_valid=0.
- OP funct3=000, funct7b5=1 -> out_ctrl=1011.
- OP-IMM funct3=101, funct7b5=1, imm=1, rs1=4 -> out_ctrl=1010, out_b=1.
- BRANCH funct3=110 -> ctrl 0010. BRANCH funct3=010 -> out_illegal=1. Opcode 1111111 -> out_illegal=1, a=b=0.
- Forwarding (with ALU_ISSUE_FWD_EN), rs1_addr=5:
  - fwd_ex (rd=5, data=0xAA) and fwd_wb (rd=5, data=0xBB) both valid -> out_a=0xAA.
  - rd=0 match -> register data used.
  - Without the macro -> register data used.
- Backpressure: out_ready=0, push A,B -> in_ready=0 after B, out holds A.
  - Raise out_ready -> A, then B, in order, no loss.
  - Simultaneous accept+drain sustains one entry per cycle.
- Flush with both entries full:
  - Next cycle out_valid=0, in_ready=1.
  - Input offered in the flush cycle does not appear.
- rst_n=0 during the same stall: both entries discarded; all outputs zero next cycle.
